// File: rtl/bfm_apb_pkg.sv
// Shared types and constants for the BFM APB slot bridge.
// Holds the bridge state encoding, the APB response codes and a width helper.
package bfm_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

    // Ceiling log2 for elaboration-time widths; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bfm_apb_slot_decode.sv
// Slot field to one-hot downstream select, plus a flag telling whether the
// slot index addresses an existing downstream slave.
module bfm_apb_slot_decode #(
    parameter int NSLOTS    = 16,
    parameter int SEL_WIDTH = 4
) (
    input  logic [SEL_WIDTH-1:0] slot,
    output logic [NSLOTS-1:0]    psel_onehot,
    output logic                 mapped
);

    // One-hot decode and range check of the slot index.
    always_comb begin
        psel_onehot = {NSLOTS{1'b0}};
        for (int i = 0; i < NSLOTS; i++) begin
            psel_onehot[i] = (slot == SEL_WIDTH'(i));
        end
        mapped = (32'(slot) < 32'(NSLOTS));
    end

endmodule

// File: rtl/bfm_apb_slot_bridge.sv
// APB3 bridge: captures one upstream transfer, replays it on the slave chosen
// by the slot field of the address, and returns the response upstream.
module bfm_apb_slot_bridge
    import bfm_apb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NSLOTS          = 16,
    parameter int SEL_LSB         = 24,
    parameter int SEL_WIDTH       = 4,
    parameter int TIMEOUT         = 256,
    parameter int ERR_ON_UNMAPPED = 1,
    parameter int TPD             = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL_PM,
    input  logic [ADDR_WIDTH-1:0] PADDR_PM,
    input  logic                  PWRITE_PM,
    input  logic                  PENABLE_PM,
    input  logic [DATA_WIDTH-1:0] PWDATA_PM,
    output logic [DATA_WIDTH-1:0] PRDATA_PM,
    output logic                  PREADY_PM,
    output logic                  PSLVERR_PM,
    output logic [NSLOTS-1:0]     PSEL_SC,
    output logic [ADDR_WIDTH-1:0] PADDR_SC,
    output logic                  PWRITE_SC,
    output logic                  PENABLE_SC,
    output logic [DATA_WIDTH-1:0] PWDATA_SC,
    input  logic [DATA_WIDTH-1:0] PRDATA_SC,
    input  logic                  PREADY_SC,
    input  logic                  PSLVERR_SC,
    output logic                  BUSY,
    output logic                  TIMEOUT_EVT
);

    localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic UNMAPPED_RESP = (ERR_ON_UNMAPPED != 0) ? SLVERR : OKAY;

    // Output delay only matters to behavioural slave models; the RTL is zero-delay.
    if (TPD < 0) begin : g_tpd_unused
    end

    apb_state_e            state_r, state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] rdata_r, prdata_pm_r, pwdata_sc_r;
    logic [ADDR_WIDTH-1:0] paddr_sc_r;
    logic [NSLOTS-1:0]     psel_sc_r, onehot_s;
    logic                  err_r, pready_pm_r, pslverr_pm_r, pwrite_sc_r, penable_sc_r;
    logic                  busy_r, timeout_evt_r;
    logic                  setup_s, mapped_s, done_s, tmo_s, respond_s;
    logic [SEL_WIDTH-1:0]  slot_s;

    assign slot_s    = PADDR_PM[SEL_LSB +: SEL_WIDTH];
    assign setup_s   = PSEL_PM & ~PENABLE_PM;
    assign respond_s = PSEL_PM & PENABLE_PM;
    assign done_s    = (state_r == ACCESS) & PREADY_SC;
    assign tmo_s     = (state_r == ACCESS) & ~PREADY_SC & (TIMEOUT != 0) & (cnt_r == CNT_LAST);

    bfm_apb_slot_decode #(
        .NSLOTS    (NSLOTS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_decode (
        .slot        (slot_s),
        .psel_onehot (onehot_s),
        .mapped      (mapped_s)
    );

    // Bridge state register.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; unmapped slots skip the downstream phases entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_s = mapped_s ? SETUP : RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP:  state_s = ACCESS;
            ACCESS: begin
                if (done_s || tmo_s) begin
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered downstream drive, watchdog and upstream response.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            psel_sc_r     <= {NSLOTS{1'b0}};
            paddr_sc_r    <= {ADDR_WIDTH{1'b0}};
            pwdata_sc_r   <= {DATA_WIDTH{1'b0}};
            pwrite_sc_r   <= 1'b0;
            penable_sc_r  <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            rdata_r       <= {DATA_WIDTH{1'b0}};
            err_r         <= 1'b0;
            prdata_pm_r   <= {DATA_WIDTH{1'b0}};
            pready_pm_r   <= 1'b0;
            pslverr_pm_r  <= 1'b0;
            timeout_evt_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            pready_pm_r   <= 1'b0;
            pslverr_pm_r  <= 1'b0;
            timeout_evt_r <= 1'b0;
            busy_r        <= (state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (setup_s && mapped_s) begin
                        psel_sc_r   <= onehot_s;
                        paddr_sc_r  <= PADDR_PM;
                        pwdata_sc_r <= PWDATA_PM;
                        pwrite_sc_r <= PWRITE_PM;
                    end else if (setup_s) begin
                        err_r   <= UNMAPPED_RESP;
                        rdata_r <= {DATA_WIDTH{1'b0}};
                    end
                end
                SETUP: begin
                    penable_sc_r <= 1'b1;
                    cnt_r        <= {CNT_W{1'b0}};
                end
                ACCESS: begin
                    if (done_s || tmo_s) begin
                        rdata_r       <= (done_s && !pwrite_sc_r) ? PRDATA_SC : {DATA_WIDTH{1'b0}};
                        err_r         <= done_s ? PSLVERR_SC : SLVERR;
                        timeout_evt_r <= tmo_s;
                        psel_sc_r     <= {NSLOTS{1'b0}};
                        paddr_sc_r    <= {ADDR_WIDTH{1'b0}};
                        pwdata_sc_r   <= {DATA_WIDTH{1'b0}};
                        pwrite_sc_r   <= 1'b0;
                        penable_sc_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                end
                RESP: begin
                    // A master that left the access phase has aborted; drop the response.
                    if (respond_s) begin
                        pready_pm_r  <= 1'b1;
                        prdata_pm_r  <= rdata_r;
                        pslverr_pm_r <= err_r;
                    end
                end
                default: begin
                    psel_sc_r    <= {NSLOTS{1'b0}};
                    penable_sc_r <= 1'b0;
                end
            endcase
        end
    end

    assign PRDATA_PM   = prdata_pm_r;
    assign PREADY_PM   = pready_pm_r;
    assign PSLVERR_PM  = pslverr_pm_r;
    assign PSEL_SC     = psel_sc_r;
    assign PADDR_SC    = paddr_sc_r;
    assign PWRITE_SC   = pwrite_sc_r;
    assign PENABLE_SC  = penable_sc_r;
    assign PWDATA_SC   = pwdata_sc_r;
    assign BUSY        = busy_r;
    assign TIMEOUT_EVT = timeout_evt_r;

endmodule

// File: tb/tb_bfm_apb_slot_bridge.sv
// Directed bench for bfm_apb_slot_bridge: an 8-slot erroring instance and a
// 4-slot OKAY-on-unmapped instance share the same upstream/downstream stimulus.
module tb_bfm_apb_slot_bridge;

    logic        PCLK, PRESETN;
    logic        PSEL_PM, PWRITE_PM, PENABLE_PM;
    logic [31:0] PADDR_PM, PWDATA_PM, PRDATA_SC;
    logic        PREADY_SC, PSLVERR_SC;

    logic [31:0] a_PRDATA_PM, a_PADDR_SC, a_PWDATA_SC;
    logic        a_PREADY_PM, a_PSLVERR_PM, a_PWRITE_SC, a_PENABLE_SC, a_BUSY, a_TIMEOUT_EVT;
    logic [7:0]  a_PSEL_SC;
    logic [31:0] b_PRDATA_PM, b_PADDR_SC, b_PWDATA_SC;
    logic        b_PREADY_PM, b_PSLVERR_PM, b_PWRITE_SC, b_PENABLE_SC, b_BUSY, b_TIMEOUT_EVT;
    logic [3:0]  b_PSEL_SC;

    int checks = 0;
    int errors = 0;

    int          r_lat, r_en, r_tmo_cyc, b_lat;
    logic [31:0] r_rdata, r_pwdata1, r_paddr1, r_paddr_end, b_rdata;
    logic [7:0]  r_psel1, r_psel_end;
    logic        r_err, r_pwrite1, r_tmo, r_psel_any, r_busy0, b_err;

    bfm_apb_slot_bridge #(.NSLOTS(8), .TIMEOUT(8), .ERR_ON_UNMAPPED(1)) dut_a (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM),
        .PWRITE_PM(PWRITE_PM), .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM),
        .PRDATA_PM(a_PRDATA_PM), .PREADY_PM(a_PREADY_PM), .PSLVERR_PM(a_PSLVERR_PM),
        .PSEL_SC(a_PSEL_SC), .PADDR_SC(a_PADDR_SC), .PWRITE_SC(a_PWRITE_SC),
        .PENABLE_SC(a_PENABLE_SC), .PWDATA_SC(a_PWDATA_SC), .PRDATA_SC(PRDATA_SC),
        .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC), .BUSY(a_BUSY),
        .TIMEOUT_EVT(a_TIMEOUT_EVT)
    );

    bfm_apb_slot_bridge #(.NSLOTS(4), .TIMEOUT(8), .ERR_ON_UNMAPPED(0)) dut_b (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM),
        .PWRITE_PM(PWRITE_PM), .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM),
        .PRDATA_PM(b_PRDATA_PM), .PREADY_PM(b_PREADY_PM), .PSLVERR_PM(b_PSLVERR_PM),
        .PSEL_SC(b_PSEL_SC), .PADDR_SC(b_PADDR_SC), .PWRITE_SC(b_PWRITE_SC),
        .PENABLE_SC(b_PENABLE_SC), .PWDATA_SC(b_PWDATA_SC), .PRDATA_SC(PRDATA_SC),
        .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC), .BUSY(b_BUSY),
        .TIMEOUT_EVT(b_TIMEOUT_EVT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // One upstream transfer; cycle 0 is the setup phase. The slave raises
    // PREADY_SC from cycle ready_at on (never if negative).
    task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input int ready_at, input logic [31:0] rd, input logic serr);
        r_lat = -1; r_en = 0; r_tmo = 1'b0; r_tmo_cyc = -1; r_psel_any = 1'b0;
        r_rdata = 32'h0; r_err = 1'b0; r_psel1 = 8'h0; r_pwdata1 = 32'h0; r_paddr1 = 32'h0;
        r_pwrite1 = 1'b0; r_psel_end = 8'h0; r_paddr_end = 32'h0; r_busy0 = 1'b0;
        b_lat = -1; b_err = 1'b0; b_rdata = 32'h0;
        for (int c = 0; c < 40 && r_lat < 0; c++) begin
            if (c == 0) r_busy0 = a_BUSY;
            if (c == 1) begin
                r_psel1 = a_PSEL_SC; r_pwdata1 = a_PWDATA_SC;
                r_paddr1 = a_PADDR_SC; r_pwrite1 = a_PWRITE_SC;
            end
            if (a_PENABLE_SC) r_en++;
            if (a_PSEL_SC != 8'h0) r_psel_any = 1'b1;
            if (a_TIMEOUT_EVT) begin r_tmo = 1'b1; r_tmo_cyc = c; end
            if (b_PREADY_PM && b_lat < 0) begin
                b_lat = c; b_err = b_PSLVERR_PM; b_rdata = b_PRDATA_PM;
            end
            if (a_PREADY_PM) begin
                r_lat = c; r_rdata = a_PRDATA_PM; r_err = a_PSLVERR_PM;
                r_psel_end = a_PSEL_SC; r_paddr_end = a_PADDR_SC;
            end
            if (r_lat < 0) begin
                PSEL_PM = 1'b1; PENABLE_PM = (c > 0); PADDR_PM = addr;
                PWRITE_PM = wr; PWDATA_PM = wd; PRDATA_SC = rd; PSLVERR_SC = serr;
                PREADY_SC = (ready_at >= 0) && (c >= ready_at);
                @(posedge PCLK); #1;
            end
        end
        PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PREADY_SC = 1'b0; PSLVERR_SC = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_reset();
        PRESETN = 1'b0; PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PWRITE_PM = 1'b0;
        PADDR_PM = 32'h0; PWDATA_PM = 32'h0; PRDATA_SC = 32'h0;
        PREADY_SC = 1'b0; PSLVERR_SC = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if ({a_PSEL_SC, a_PENABLE_SC, a_PWRITE_SC} !== 10'h0) begin
            errors++; $display("FAIL reset_ctrl got %h want 0", {a_PSEL_SC, a_PENABLE_SC, a_PWRITE_SC});
        end
        checks++;
        if ({a_PADDR_SC, a_PWDATA_SC, a_PRDATA_PM} !== 96'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", {a_PADDR_SC, a_PWDATA_SC, a_PRDATA_PM});
        end
        checks++;
        if ({a_PREADY_PM, a_PSLVERR_PM, a_BUSY, a_TIMEOUT_EVT} !== 4'h0) begin
            errors++; $display("FAIL reset_status got %h want 0", {a_PREADY_PM, a_PSLVERR_PM, a_BUSY, a_TIMEOUT_EVT});
        end
        PRESETN = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_write();
        run_xfer(32'h0300_0010, 1'b1, 32'hA5A5_1234, 2, 32'hDEAD_0000, 1'b0);
        checks++;
        if (r_psel1 !== 8'h08) begin errors++; $display("FAIL wr_psel got %h want 08", r_psel1); end
        checks++;
        if (r_pwdata1 !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_pwdata got %h want a5a51234", r_pwdata1); end
        checks++;
        if (r_paddr1 !== 32'h0300_0010 || r_pwrite1 !== 1'b1) begin
            errors++; $display("FAIL wr_addr got %h/%b want 03000010/1", r_paddr1, r_pwrite1);
        end
        checks++;
        if (r_lat !== 4) begin errors++; $display("FAIL wr_latency got %0d want 4", r_lat); end
        checks++;
        if (r_err !== 1'b0 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_resp got %b/%h want 0/0", r_err, r_rdata);
        end
        checks++;
        if (r_en !== 1 || r_psel_end !== 8'h0 || r_paddr_end !== 32'h0) begin
            errors++; $display("FAIL wr_release got en=%0d psel=%h addr=%h want 1/0/0", r_en, r_psel_end, r_paddr_end);
        end
    endtask

    task automatic test_read_wait();
        run_xfer(32'h0500_0004, 1'b0, 32'h0, 5, 32'hCAFE_F00D, 1'b0);
        checks++;
        if (r_psel1 !== 8'h20 || r_pwrite1 !== 1'b0) begin
            errors++; $display("FAIL rd_psel got %h/%b want 20/0", r_psel1, r_pwrite1);
        end
        checks++;
        if (r_en !== 4) begin errors++; $display("FAIL rd_enable_cycles got %0d want 4", r_en); end
        checks++;
        if (r_rdata !== 32'hCAFE_F00D || r_err !== 1'b0) begin
            errors++; $display("FAIL rd_data got %h/%b want cafef00d/0", r_rdata, r_err);
        end
        checks++;
        if (r_lat !== 7) begin errors++; $display("FAIL rd_latency got %0d want 7", r_lat); end
    endtask

    task automatic test_timeout();
        run_xfer(32'h0200_0000, 1'b0, 32'h0, -1, 32'h5555_AAAA, 1'b0);
        checks++;
        if (r_tmo !== 1'b1 || r_tmo_cyc !== 10) begin
            errors++; $display("FAIL tmo_event got %b at %0d want 1 at 10", r_tmo, r_tmo_cyc);
        end
        checks++;
        if (r_en !== 8) begin errors++; $display("FAIL tmo_enable_cycles got %0d want 8", r_en); end
        checks++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_lat !== 11) begin
            errors++; $display("FAIL tmo_resp got %b/%h/%0d want 1/0/11", r_err, r_rdata, r_lat);
        end
        checks++;
        if (r_psel_end !== 8'h0) begin errors++; $display("FAIL tmo_psel got %h want 0", r_psel_end); end
    endtask

    task automatic test_ready_at_limit();
        run_xfer(32'h0200_0008, 1'b0, 32'h0, 9, 32'h1234_5678, 1'b0);
        checks++;
        if (r_tmo !== 1'b0) begin errors++; $display("FAIL tie_tmo got %b want 0", r_tmo); end
        checks++;
        if (r_err !== 1'b0 || r_rdata !== 32'h1234_5678 || r_lat !== 11) begin
            errors++; $display("FAIL tie_resp got %b/%h/%0d want 0/12345678/11", r_err, r_rdata, r_lat);
        end
    endtask

    task automatic test_unmapped();
        run_xfer(32'h0900_0000, 1'b0, 32'h0, 2, 32'h7777_7777, 1'b0);
        checks++;
        if (r_psel_any !== 1'b0 || r_en !== 0) begin
            errors++; $display("FAIL unm_psel got %b/%0d want 0/0", r_psel_any, r_en);
        end
        checks++;
        if (r_lat !== 2 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL unm_err_resp got %0d/%b/%h want 2/1/0", r_lat, r_err, r_rdata);
        end
        checks++;
        if (b_lat !== 2 || b_err !== 1'b0 || b_rdata !== 32'h0) begin
            errors++; $display("FAIL unm_okay_resp got %0d/%b/%h want 2/0/0", b_lat, b_err, b_rdata);
        end
    endtask

    task automatic test_slverr();
        run_xfer(32'h0600_0020, 1'b0, 32'h0, 3, 32'h0F0F_0F0F, 1'b1);
        checks++;
        if (r_err !== 1'b1 || r_rdata !== 32'h0F0F_0F0F || r_lat !== 5) begin
            errors++; $display("FAIL slverr_resp got %b/%h/%0d want 1/0f0f0f0f/5", r_err, r_rdata, r_lat);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(32'h0300_0100, 1'b1, 32'h0000_00FF, 2, 32'h0, 1'b0);
        checks++;
        if (r_lat !== 4) begin errors++; $display("FAIL b2b_first got %0d want 4", r_lat); end
        run_xfer(32'h0100_0200, 1'b0, 32'h0, 2, 32'h0BAD_BEEF, 1'b0);
        checks++;
        if (r_busy0 !== 1'b0 || r_lat !== 4 || r_rdata !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL b2b_second got %b/%0d/%h want 0/4/0badbeef", r_busy0, r_lat, r_rdata);
        end
    endtask

    task automatic test_reset_abort();
        PSEL_PM = 1'b1; PENABLE_PM = 1'b0; PADDR_PM = 32'h0400_0040;
        PWRITE_PM = 1'b1; PWDATA_PM = 32'h1111_2222; PREADY_SC = 1'b0;
        @(posedge PCLK); #1;
        PENABLE_PM = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (a_PENABLE_SC !== 1'b1 || a_PSEL_SC !== 8'h10) begin
            errors++; $display("FAIL abort_access got %b/%h want 1/10", a_PENABLE_SC, a_PSEL_SC);
        end
        #2;
        PRESETN = 1'b0;
        #1;
        checks++;
        if ({a_PSEL_SC, a_PENABLE_SC, a_PWRITE_SC, a_BUSY} !== 11'h0 || {a_PADDR_SC, a_PWDATA_SC} !== 64'h0) begin
            errors++; $display("FAIL abort_async got %h/%h want 0/0",
                               {a_PSEL_SC, a_PENABLE_SC, a_PWRITE_SC, a_BUSY}, {a_PADDR_SC, a_PWDATA_SC});
        end
        PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (a_PREADY_PM !== 1'b0 || a_BUSY !== 1'b0) begin
            errors++; $display("FAIL abort_no_resp got %b/%b want 0/0", a_PREADY_PM, a_BUSY);
        end
        run_xfer(32'h0100_0040, 1'b1, 32'h3333_4444, 2, 32'h0, 1'b0);
        checks++;
        if (r_busy0 !== 1'b0 || r_lat !== 4 || r_err !== 1'b0 || r_pwdata1 !== 32'h3333_4444) begin
            errors++; $display("FAIL abort_recover got %b/%0d/%b/%h want 0/4/0/33334444",
                               r_busy0, r_lat, r_err, r_pwdata1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_ready_at_limit();
        test_unmapped();
        test_slverr();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfm_apb_slot_bridge.md
Name: bfm_apb_slot_bridge

Overview:
Single-clock, parametrised APB3 bridge for the BFM test environment. It takes one upstream APB master transfer, decodes a slot index from the captured address, and replays the transfer on the selected one of NSLOTS downstream slaves. It adds behaviour the earlier bridge lacked: configurable widths and slot count, unmapped-slot error response, a downstream timeout watchdog, and status outputs. It sits between the BFM master and the peripheral APB fabric.

Parameters:
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width on both sides
NSLOTS, 16, number of downstream slaves; legal range 1..2**SEL_WIDTH
SEL_LSB, 24, LSB of the slot-index field in PADDR
SEL_WIDTH, 4, width of the slot-index field
TIMEOUT, 256, ACCESS-phase cycle limit before forced completion; 0 disables the watchdog
ERR_ON_UNMAPPED, 1, 1: an unmapped slot returns PSLVERR_PM=1; 0: it returns OKAY
TPD, 1, simulation delay on downstream outputs in ns; no effect on synthesis

Ports:
PCLK  in  1  clock for both sides
PRESETN  in  1  asynchronous active-low reset
PSEL_PM  in  1  upstream select
PADDR_PM  in  ADDR_WIDTH  upstream address
PWRITE_PM  in  1  upstream write
PENABLE_PM  in  1  upstream enable
PWDATA_PM  in  DATA_WIDTH  upstream write data
PRDATA_PM  out  DATA_WIDTH  upstream read data, registered
PREADY_PM  out  1  upstream ready, one-cycle pulse
PSLVERR_PM  out  1  upstream error, valid with PREADY_PM
PSEL_SC  out  NSLOTS  downstream one-hot select
PADDR_SC  out  ADDR_WIDTH  downstream address
PWRITE_SC  out  1  downstream write
PENABLE_SC  out  1  downstream enable
PWDATA_SC  out  DATA_WIDTH  downstream write data
PRDATA_SC  in  DATA_WIDTH  downstream read data
PREADY_SC  in  1  downstream ready
PSLVERR_SC  in  1  downstream error
BUSY  out  1  high in any state other than IDLE
TIMEOUT_EVT  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (asynchronous, PRESETN=0): state=IDLE. All outputs are 0, including the captured address, data and write registers.
- All outputs are registered; there is no combinational path from upstream inputs to downstream outputs.
- IDLE: when PSEL_PM=1 and PENABLE_PM=0 (setup phase), capture PADDR_PM, PWDATA_PM and PWRITE_PM, and compute slot = PADDR_PM[SEL_LSB +: SEL_WIDTH].
  - If slot < NSLOTS, go to SETUP.
  - Otherwise go to RESP with err=ERR_ON_UNMAPPED and rdata=0. No downstream PSEL is asserted.
- SETUP (one cycle): PSEL_SC[slot]=1, PENABLE_SC=0, address, write and data driven. Next state is ACCESS.
- ACCESS: PENABLE_SC=1. A watchdog counter counts from 0, one increment per cycle spent in ACCESS.
  - PREADY_SC=1: capture PRDATA_SC (reads only; writes return 0) and PSLVERR_SC, then go to RESP.
  - Otherwise, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: pulse TIMEOUT_EVT, set err=1 and rdata=0, then go to RESP.
  - If PREADY_SC and the timeout occur in the same cycle, PREADY_SC wins and TIMEOUT_EVT is not pulsed.
- RESP (one cycle):
  - All downstream controls return to 0. PADDR_SC and PWDATA_SC are zeroed.
  - PREADY_PM=1 with PRDATA_PM=rdata and PSLVERR_PM=err, but only if PSEL_PM=1 and PENABLE_PM=1. Otherwise the response is discarded (upstream abort).
  - Next state is IDLE.
- PREADY_PM, PSLVERR_PM and TIMEOUT_EVT are single-cycle pulses. PRDATA_PM holds its value until the next response.
- Minimum upstream latency: setup-phase cycle → PREADY_PM is 4 cycles later for a zero-wait slave; 2 cycles for an unmapped slot.
- Upstream signals are ignored outside IDLE and RESP. Back-to-back transfers are supported: a new setup phase can be accepted in the cycle after RESP.
- Reset asserted mid-transfer aborts immediately: all selects and enables drop asynchronously, and no response is issued.

Decomposition:
- Shared package bfm_apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP} (2-bit)
  - APB response constants OKAY=0, SLVERR=1
  - a clog2 function for the watchdog counter width, clog2(TIMEOUT+1)
- One sub-module, bfm_apb_slot_decode: a combinational slot field → one-hot PSEL vector of NSLOTS bits plus a "mapped" flag. It is instantiated once, and its output is registered in the bridge.

Test Plan:
- Write to 0x0300_0010 with data 0xA5A5_1234, slave zero-wait → PSEL_SC=0x0008; PWDATA_SC=0xA5A5_1234 in SETUP; PREADY_PM 4 cycles after setup; PSLVERR_PM=0.
- Read from 0x0500_0004, slave inserts 3 wait states returning 0xCAFE_F00D → PENABLE_SC high for 4 cycles; PRDATA_PM=0xCAFE_F00D; latency 7 cycles.
- NSLOTS=4, access to 0x0900_0000 → no PSEL_SC asserted; PREADY_PM after 2 cycles; PSLVERR_PM=1 (ERR_ON_UNMAPPED=1) or 0 (ERR_ON_UNMAPPED=0).
- TIMEOUT=8, slave never ready → TIMEOUT_EVT after 8 ACCESS cycles; PSLVERR_PM=1; PRDATA_PM=0; PSEL_SC back to 0.
- PREADY_SC asserted in the same cycle as the watchdog limit → normal completion; TIMEOUT_EVT stays 0.
- PRESETN pulsed low during ACCESS → all outputs 0 immediately; after release, the next transfer completes normally with BUSY=0 between transfers.
